cve2_counter_csr_port: RTL and testbench

- CSR-side access port for the bank of cve2 performance counters.
- Accepts single 32-bit CSR read/write requests over a valid/ready handshake.
- Drives the per-counter low/high write strobes and write data, and returns read data over a one-cycle response.
- Provides snapshot-consistent 64-bit reads: a low-word read latches the high word.
- Owns the count-inhibit register and gates per-counter increment events with it.

---
 rtl/cve2_counter_csr_port.sv | 132 +++++++++++++
 tb/tb_cve2_counter_csr_port.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/cve2_counter_csr_port.sv
// cve2_counter_csr_port: CSR access port for the performance counter bank.
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   req_valid_i/req_ready_o        request handshake (one request per 2 cycles)
//   req_we_i, req_idx_i, req_hi_i  write enable, counter index (4'hF = inhibit), word select
//   req_wdata_i                    write data
//   rsp_valid_o/rsp_rdata_o/rsp_err_o  one-cycle response
//   event_i/cnt_inc_o              raw events and inhibit-gated increments
//   cnt_val_i                      live 64-bit counter values, counter i at [64*i+63:64*i]
//   cnt_we_o/cnth_we_o/cnt_wdata_o low/high word write strobes and data
//   inhibit_o                      count-inhibit register
module cve2_counter_csr_port #(
    parameter int unsigned                NumCounters   = 3,
    parameter logic [NumCounters-1:0]     InhibitRstVal = '0
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_we_i,
    input  logic [3:0]                req_idx_i,
    input  logic                      req_hi_i,
    input  logic [31:0]               req_wdata_i,
    output logic                      rsp_valid_o,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_err_o,
    input  logic [NumCounters-1:0]    event_i,
    output logic [NumCounters-1:0]    cnt_inc_o,
    input  logic [64*NumCounters-1:0] cnt_val_i,
    output logic [NumCounters-1:0]    cnt_we_o,
    output logic [NumCounters-1:0]    cnth_we_o,
    output logic [31:0]               cnt_wdata_o,
    output logic [NumCounters-1:0]    inhibit_o
);
    typedef enum logic {IDLE, RESP} state_t;

    state_t                 state;
    logic [NumCounters-1:0] inhibit;
    logic [NumCounters-1:0] inh_wdata;
    logic                   inh_pend;
    logic                   shadow_valid;
    logic [3:0]             shadow_idx;
    logic [31:0]            shadow;
    logic [NumCounters-1:0] sel_oh;
    logic [63:0]            live;
    logic                   is_inh;
    logic                   legal_cnt;
    logic                   shadow_hit;
    logic [31:0]            rdata;

    always_comb begin
        sel_oh = '0;
        live   = '0;
        for (int k = 0; k < NumCounters; k++) begin
            if (req_idx_i == 4'(k)) begin
                sel_oh[k] = 1'b1;
                live      = cnt_val_i[64*k +: 64];
            end
        end
    end

    assign is_inh     = req_idx_i == 4'hF;
    assign legal_cnt  = |sel_oh;
    assign shadow_hit = shadow_valid && shadow_idx == req_idx_i;
    // High reads return the latched snapshot only when it belongs to this counter.
    assign rdata = is_inh ? {{(32-NumCounters){1'b0}}, inhibit} :
                   req_hi_i ? (shadow_hit ? shadow : live[63:32]) : live[31:0];

    assign req_ready_o = state == IDLE;
    assign cnt_inc_o   = event_i & ~inhibit;
    assign inhibit_o   = inhibit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            inhibit      <= InhibitRstVal;
            inh_wdata    <= '0;
            inh_pend     <= 1'b0;
            shadow_valid <= 1'b0;
            shadow_idx   <= '0;
            shadow       <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_rdata_o  <= '0;
            rsp_err_o    <= 1'b0;
            cnt_we_o     <= '0;
            cnth_we_o    <= '0;
            cnt_wdata_o  <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            cnt_we_o    <= '0;
            cnth_we_o   <= '0;
            cnt_wdata_o <= '0;
            inh_pend    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= !(legal_cnt || is_inh);
                        if (req_we_i && legal_cnt) begin
                            cnt_we_o    <= req_hi_i ? '0 : sel_oh;
                            cnth_we_o   <= req_hi_i ? sel_oh : '0;
                            cnt_wdata_o <= req_wdata_i;
                            if (shadow_idx == req_idx_i) shadow_valid <= 1'b0;
                        end
                        // Inhibit update is deferred to the end of the response cycle.
                        if (req_we_i && is_inh) begin
                            inh_pend  <= 1'b1;
                            inh_wdata <= req_wdata_i[NumCounters-1:0];
                        end
                        if (!req_we_i && (legal_cnt || is_inh)) begin
                            rsp_rdata_o <= rdata;
                            if (legal_cnt && !req_hi_i) begin
                                shadow       <= live[63:32];
                                shadow_idx   <= req_idx_i;
                                shadow_valid <= 1'b1;
                            end
                            if (legal_cnt && req_hi_i && shadow_hit) shadow_valid <= 1'b0;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                    if (inh_pend) inhibit <= inh_wdata;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cve2_counter_csr_port.sv
// tb_cve2_counter_csr_port: directed self-checking bench for cve2_counter_csr_port.
module tb_cve2_counter_csr_port;
    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         req_valid_i = 1'b0;
    logic         req_ready_o;
    logic         req_we_i = 1'b0;
    logic [3:0]   req_idx_i = '0;
    logic         req_hi_i = 1'b0;
    logic [31:0]  req_wdata_i = '0;
    logic         rsp_valid_o;
    logic [31:0]  rsp_rdata_o;
    logic         rsp_err_o;
    logic [2:0]   event_i = '0;
    logic [2:0]   cnt_inc_o;
    logic [191:0] cnt_val_i = '0;
    logic [2:0]   cnt_we_o;
    logic [2:0]   cnth_we_o;
    logic [31:0]  cnt_wdata_o;
    logic [2:0]   inhibit_o;
    int           checks = 0;
    int           failures = 0;

    cve2_counter_csr_port #(.NumCounters(3), .InhibitRstVal(3'b000)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_idx_i(req_idx_i), .req_hi_i(req_hi_i),
        .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .event_i(event_i), .cnt_inc_o(cnt_inc_o), .cnt_val_i(cnt_val_i),
        .cnt_we_o(cnt_we_o), .cnth_we_o(cnth_we_o), .cnt_wdata_o(cnt_wdata_o),
        .inhibit_o(inhibit_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one request, returns #1 after the accepting edge (inside the response cycle).
    task automatic issue(input logic we, input logic [3:0] idx, input logic hi, input logic [31:0] wd);
        int n = 0;
        @(negedge clk_i);
        while (!req_ready_o && n < 10) begin
            @(negedge clk_i);
            n++;
        end
        check("ready_timeout", 32'(n < 10), 32'd1);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_idx_i   = idx;
        req_hi_i    = hi;
        req_wdata_i = wd;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ready", 32'(req_ready_o), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_inhibit", 32'(inhibit_o), 32'd0);
        check("rst_cnt_we", 32'(cnt_we_o), 32'd0);
        check("rst_cnth_we", 32'(cnth_we_o), 32'd0);
        check("rst_rdata", rsp_rdata_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check("idle_ready", 32'(req_ready_o), 32'd1);
        check("idle_rsp_valid", 32'(rsp_valid_o), 32'd0);

        // Snapshot-consistent 64-bit read across a carry
        cnt_val_i[127:64] = 64'h0000_0001_FFFF_FFFF;
        issue(1'b0, 4'd1, 1'b0, 32'h0);
        check("lo_rsp_valid", 32'(rsp_valid_o), 32'd1);
        check("lo_ready", 32'(req_ready_o), 32'd0);
        check("lo_rdata", rsp_rdata_o, 32'hFFFF_FFFF);
        check("lo_err", 32'(rsp_err_o), 32'd0);
        cnt_val_i[127:64] = 64'h0000_0002_0000_0000;
        @(posedge clk_i);
        #1;
        check("resp_pulse_drop", 32'(rsp_valid_o), 32'd0);
        issue(1'b0, 4'd1, 1'b1, 32'h0);
        check("hi_shadow", rsp_rdata_o, 32'h0000_0001);
        issue(1'b0, 4'd1, 1'b1, 32'h0);
        check("hi_live", rsp_rdata_o, 32'h0000_0002);

        // High-word write to counter 0
        issue(1'b1, 4'd0, 1'b1, 32'hDEAD_BEEF);
        check("wr_cnth_we", 32'(cnth_we_o), 32'd1);
        check("wr_cnt_we", 32'(cnt_we_o), 32'd0);
        check("wr_wdata", cnt_wdata_o, 32'hDEAD_BEEF);
        check("wr_rsp_valid", 32'(rsp_valid_o), 32'd1);
        check("wr_rdata", rsp_rdata_o, 32'd0);
        check("wr_ready", 32'(req_ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        check("wr_strobe_drop", 32'(cnth_we_o), 32'd0);
        check("wr_wdata_drop", cnt_wdata_o, 32'd0);

        // Inhibit write gates increments after the response cycle
        event_i = 3'b111;
        #1;
        check("inc_open", 32'(cnt_inc_o), 32'b111);
        issue(1'b1, 4'hF, 1'b0, 32'hFFFF_FFFA);
        check("inh_resp_inc", 32'(cnt_inc_o), 32'b111);
        check("inh_no_strobe", 32'({cnt_we_o, cnth_we_o}), 32'd0);
        @(posedge clk_i);
        #1;
        check("inh_inc_gated", 32'(cnt_inc_o), 32'b101);
        check("inh_value", 32'(inhibit_o), 32'b010);
        issue(1'b0, 4'hF, 1'b0, 32'h0);
        check("inh_read", rsp_rdata_o, 32'h0000_0002);
        event_i = 3'b000;

        // Illegal index
        issue(1'b0, 4'd5, 1'b0, 32'h0);
        check("ill_rd_err", 32'(rsp_err_o), 32'd1);
        check("ill_rd_rdata", rsp_rdata_o, 32'd0);
        check("ill_rd_strobe", 32'({cnt_we_o, cnth_we_o}), 32'd0);
        issue(1'b1, 4'd5, 1'b1, 32'h1234_5678);
        check("ill_wr_err", 32'(rsp_err_o), 32'd1);
        check("ill_wr_strobe", 32'({cnt_we_o, cnth_we_o}), 32'd0);
        issue(1'b1, 4'd3, 1'b0, 32'h0000_0007);
        check("ill3_err", 32'(rsp_err_o), 32'd1);
        @(posedge clk_i);
        #1;
        check("ill_inhibit_kept", 32'(inhibit_o), 32'b010);

        // Write to the snapshotted counter invalidates the shadow
        cnt_val_i[191:128] = 64'h0000_0007_0000_0005;
        issue(1'b0, 4'd2, 1'b0, 32'h0);
        check("sh_lo", rsp_rdata_o, 32'h0000_0005);
        issue(1'b1, 4'd2, 1'b0, 32'h0000_0011);
        check("sh_wr_cnt_we", 32'(cnt_we_o), 32'b100);
        check("sh_wr_err", 32'(rsp_err_o), 32'd0);
        cnt_val_i[191:128] = 64'h0000_0009_0000_0011;
        issue(1'b0, 4'd2, 1'b1, 32'h0);
        check("sh_hi_live", rsp_rdata_o, 32'h0000_0009);

        // Asynchronous reset during a write response
        issue(1'b1, 4'd2, 1'b1, 32'hCAFE_0000);
        check("ar_pre_strobe", 32'(cnth_we_o), 32'b100);
        #2;
        rst_ni = 1'b0;
        #1;
        check("ar_strobe", 32'(cnth_we_o), 32'd0);
        check("ar_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("ar_wdata", cnt_wdata_o, 32'd0);
        check("ar_inhibit", 32'(inhibit_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check("ar_ready", 32'(req_ready_o), 32'd1);
        check("ar_idle_valid", 32'(rsp_valid_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
